// File: rtl/ad9252_spi_pkg.sv
// ---------------------------------------------------------------------------
// ad9252_spi_pkg
// Constants, instruction-field encodings and FSM state type shared by the
// AD9252 SPI configuration-write path and the register-readback path.
// Contents:
//   INSTR_W / ADDR_W     instruction word and register address widths
//   RW_READ / RW_WRITE   value of instruction bit 15
//   W_*                  W1:W0 byte-count encodings (byte count minus 1)
//   spi_state_e          frame sequencer states
//   build_instr()        assembles a read instruction word
//   frame_bits()         instruction + data bit count for a given W1:W0
// ---------------------------------------------------------------------------
package ad9252_spi_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 13;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] W_1BYTE = 2'b00;
  localparam logic [1:0] W_2BYTE = 2'b01;
  localparam logic [1:0] W_3BYTE = 2'b10;
  localparam logic [1:0] W_4BYTE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    INSTR = 3'd2,
    DATA  = 3'd3,
    HOLD  = 3'd4
  } spi_state_e;

  // Read instruction, sent MSB first: R/W, W1:W0, A12..A0.
  function automatic logic [INSTR_W-1:0] build_instr(input logic [1:0]        len,
                                                      input logic [ADDR_W-1:0] addr);
    return {RW_READ, len, addr};
  endfunction

  // Whole-frame SCLK rising-edge count: 16 instruction bits + 8*(len+1) data bits.
  // Largest result is 48, which fits the 6-bit edge counter without wrapping.
  function automatic logic [5:0] frame_bits(input logic [1:0] len);
    return 6'(INSTR_W) + {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// ---------------------------------------------------------------------------
// spi_sclk_div
// SCLK generator: toggles a registered SCLK every CLK_DIV clk cycles while
// enabled and flags, one cycle ahead, which edge the next toggle produces.
// Disabled -> counter cleared and SCLK parked low, so every enable starts a
// fresh half-period.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            run the divider
//   o_rise          SCLK goes high at the next clk edge
//   o_fall          SCLK goes low at the next clk edge
//   o_sclk          registered SCLK, idle low
// ---------------------------------------------------------------------------
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == CNT_LAST);
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  // Half-period counter and SCLK toggle register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ad9252_spi_reader.sv
// ---------------------------------------------------------------------------
// ad9252_spi_reader
// Register-readback engine for the AD9252 3-wire SPI port. On an accepted
// request it sends a 16-bit read instruction, releases SDIO after the 16th
// falling edge, shifts in 8..32 data bits on SCLK rising edges and presents
// them right-justified with a one-cycle rd_valid pulse.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   rd_start          request, accepted only while busy = 0
//   rd_addr, rd_len   register address and byte count minus 1 (latched on accept)
//   busy              frame in progress (accept+1 through end of HOLD)
//   rd_valid, rd_data one-cycle result strobe and held result word
//   sclk_adc, csb_adc SPI clock (idle low) and chip select (active low)
//   sdio_out, sdio_oe master drive value / enable for the SDIO tristate
//   sdio_in           SDIO pad input
// All outputs are registers.
// ---------------------------------------------------------------------------
module ad9252_spi_reader
  import ad9252_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_start,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_len,
  output logic        busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        sclk_adc,
  output logic        csb_adc,
  output logic        sdio_out,
  output logic        sdio_oe,
  input  logic        sdio_in
);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("ad9252_spi_reader: CLK_DIV must be >= 2");
    end
  endgenerate

  localparam int HOLD_W = $clog2(2 * CLK_DIV);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(2 * CLK_DIV - 1);

  spi_state_e         r_state;
  spi_state_e         w_state_nxt;
  logic               w_rise;
  logic               w_fall;
  logic               w_sclk;
  logic               w_div_en;
  logic               w_hold_done;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_cap;
  logic [5:0]         r_bits;
  logic [5:0]         r_frame_bits;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_csb;
  logic               r_oe;
  logic               r_sdo;
  logic               r_busy;
  logic               r_valid;
  logic [31:0]        r_data;
  logic               w_csb_nxt;
  logic               w_oe_nxt;
  logic               w_sdo_nxt;
  logic               w_busy_nxt;
  logic               w_valid_nxt;

  // SCLK runs only while the frame is on the wire; HOLD keeps it parked low.
  assign w_div_en    = (r_state == SETUP) || (r_state == INSTR) || (r_state == DATA);
  assign w_hold_done = (r_hold == HOLD_LAST);

  spi_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (w_div_en),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_sclk  (w_sclk)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic. r_bits counts completed SCLK rising edges, so the
  // falling edge that follows rise 16 (or the last data rise) ends the phase.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (rd_start) w_state_nxt = SETUP;
        else          w_state_nxt = IDLE;
      end
      SETUP: begin
        if (w_rise) w_state_nxt = INSTR;
        else        w_state_nxt = SETUP;
      end
      INSTR: begin
        if (w_fall && (r_bits == 6'(INSTR_W))) w_state_nxt = DATA;
        else                                    w_state_nxt = INSTR;
      end
      DATA: begin
        if (w_fall && (r_bits == r_frame_bits)) w_state_nxt = HOLD;
        else                                     w_state_nxt = DATA;
      end
      HOLD: begin
        if (w_hold_done) w_state_nxt = IDLE;
        else             w_state_nxt = HOLD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered pin outputs. SDIO is
  // driven only in SETUP/INSTR and released on the same edge SCLK falls
  // for the 16th time.
  always_comb begin
    w_csb_nxt   = 1'b1;
    w_oe_nxt    = 1'b0;
    w_sdo_nxt   = 1'b0;
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_valid_nxt = (r_state == DATA) && (w_state_nxt == HOLD);
    case (w_state_nxt)
      SETUP: begin
        w_csb_nxt = 1'b0;
        w_oe_nxt  = 1'b1;
        w_sdo_nxt = RW_READ;
      end
      INSTR: begin
        w_csb_nxt = 1'b0;
        w_oe_nxt  = 1'b1;
        // New bit only at falling edges; the ADC samples on rising edges.
        w_sdo_nxt = w_fall ? r_instr[INSTR_W-2] : r_sdo;
      end
      DATA: begin
        w_csb_nxt = 1'b0;
      end
      default: begin
        w_csb_nxt = 1'b1;
      end
    endcase
  end

  // Datapath: request latch, instruction shifter, edge counter, capture
  // shifter, HOLD timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr      <= '0;
      r_cap        <= 32'd0;
      r_bits       <= 6'd0;
      r_frame_bits <= 6'd0;
      r_hold       <= '0;
      r_csb        <= 1'b1;
      r_oe         <= 1'b0;
      r_sdo        <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= 32'd0;
    end else begin
      if ((r_state == IDLE) && rd_start) begin
        r_instr      <= build_instr(rd_len, rd_addr);
        r_frame_bits <= frame_bits(rd_len);
        r_bits       <= 6'd0;
        r_cap        <= 32'd0;
      end else begin
        if ((r_state == INSTR) && w_fall) begin
          r_instr <= r_instr << 1;
        end
        if (w_rise) begin
          r_bits <= r_bits + 6'd1;
        end
        // Sample on the edge that drives SCLK high; first bit lands as MSB.
        if ((r_state == DATA) && w_rise) begin
          r_cap <= {r_cap[30:0], sdio_in};
        end
      end

      if ((r_state == HOLD) && !w_hold_done) begin
        r_hold <= r_hold + HOLD_W'(1);
      end else begin
        r_hold <= '0;
      end

      r_csb   <= w_csb_nxt;
      r_oe    <= w_oe_nxt;
      r_sdo   <= w_sdo_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      if (w_valid_nxt) begin
        r_data <= r_cap;
      end
    end
  end

  assign busy     = r_busy;
  assign rd_valid = r_valid;
  assign rd_data  = r_data;
  assign sclk_adc = w_sclk;
  assign csb_adc  = r_csb;
  assign sdio_out = r_sdo;
  assign sdio_oe  = r_oe;

endmodule

// File: tb/tb_ad9252_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_ad9252_spi_reader
// Directed bench: instance A at CLK_DIV=4, instance B at CLK_DIV=2. A small
// ADC model per instance decodes the instruction from sdio_out on SCLK rising
// edges and drives response bits on sdio_in after SCLK falling edges.
// ---------------------------------------------------------------------------
module tb_ad9252_spi_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        start [2];
  logic [12:0] addr  [2];
  logic [1:0]  len   [2];
  logic        busy  [2];
  logic        valid [2];
  logic [31:0] data  [2];
  logic        sclk  [2];
  logic        csb   [2];
  logic        sdo   [2];
  logic        oe    [2];
  logic        sdi   [2] = '{1'b0, 1'b0};
  logic [31:0] resp  [2] = '{32'd0, 32'd0};

  // ADC model state
  int          m_rise     [2] = '{0, 0};
  int          hi_cnt     [2] = '{0, 0};
  int          last_gap   [2] = '{0, 0};
  int          last_rises [2] = '{0, 0};
  int          frames     [2] = '{0, 0};
  int          vcount     [2] = '{0, 0};
  int          contention [2] = '{0, 0};
  logic [15:0] m_instr    [2] = '{16'd0, 16'd0};
  logic [15:0] last_instr [2] = '{16'd0, 16'd0};
  logic        m_csb_q    [2] = '{1'b1, 1'b1};
  logic        m_sclk_q   [2] = '{1'b0, 1'b0};
  logic        sdi_drv    [2] = '{1'b0, 1'b0};
  int          nb;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ad9252_spi_reader #(.CLK_DIV(4)) u_dut_a (
    .clk(clk), .reset(rst_n), .rd_start(start[0]), .rd_addr(addr[0]), .rd_len(len[0]),
    .busy(busy[0]), .rd_valid(valid[0]), .rd_data(data[0]), .sclk_adc(sclk[0]),
    .csb_adc(csb[0]), .sdio_out(sdo[0]), .sdio_oe(oe[0]), .sdio_in(sdi[0])
  );

  ad9252_spi_reader #(.CLK_DIV(2)) u_dut_b (
    .clk(clk), .reset(rst_n), .rd_start(start[1]), .rd_addr(addr[1]), .rd_len(len[1]),
    .busy(busy[1]), .rd_valid(valid[1]), .rd_data(data[1]), .sclk_adc(sclk[1]),
    .csb_adc(csb[1]), .sdio_out(sdo[1]), .sdio_oe(oe[1]), .sdio_in(sdi[1])
  );

  // ADC bus model, evaluated away from the active clock edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i]) vcount[i]++;
      if (sdi_drv[i] && oe[i]) contention[i]++;
      if (csb[i]) begin
        if (!m_csb_q[i]) begin
          last_instr[i] = m_instr[i];
          last_rises[i] = m_rise[i];
        end
        hi_cnt[i]++;
        m_rise[i]  = 0;
        m_instr[i] = 16'd0;
        sdi_drv[i] = 1'b0;
        sdi[i]     = 1'b0;
      end else begin
        if (m_csb_q[i]) begin
          last_gap[i] = hi_cnt[i];
          hi_cnt[i]   = 0;
          frames[i]++;
        end
        if (sclk[i] && !m_sclk_q[i]) begin
          if (m_rise[i] < 16) m_instr[i] = {m_instr[i][14:0], sdo[i]};
          m_rise[i]++;
        end else if (!sclk[i] && m_sclk_q[i]) begin
          nb = 8 * (int'(m_instr[i][14:13]) + 1);
          if (m_rise[i] >= 16 && m_rise[i] < 16 + nb) begin
            sdi[i]     = resp[i][nb - 1 - (m_rise[i] - 16)];
            sdi_drv[i] = 1'b1;
          end else begin
            sdi[i]     = 1'b0;
            sdi_drv[i] = 1'b0;
          end
        end
      end
      m_csb_q[i]  = csb[i];
      m_sclk_q[i] = sclk[i];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full frame on instance A (CLK_DIV=4) with timing and data checks.
  task automatic run_frame_a(input logic [12:0] a, input logic [1:0] l, input logic [31:0] r,
                             input logic [31:0] exp_data, input logic [15:0] exp_instr,
                             input int exp_lat, input int exp_rises);
    int c0, fr, of, vc, bc;
    logic bad_oe;
    logic [31:0] got;
    fr = -1; of = -1; vc = -1; bc = -1; bad_oe = 1'b0; got = 32'd0;
    resp[0] = r;
    @(posedge clk); #1;
    addr[0] = a; len[0] = l; start[0] = 1'b1; c0 = cyc;
    @(negedge clk);
    check_val("acc0_busy", 32'(busy[0]), 32'd0);
    check_val("acc0_csb", 32'(csb[0]), 32'd1);
    @(posedge clk); #1 start[0] = 1'b0;
    @(negedge clk);
    check_val("acc1_csb", 32'(csb[0]), 32'd0);
    check_val("acc1_busy", 32'(busy[0]), 32'd1);
    check_val("acc1_oe", 32'(oe[0]), 32'd1);
    check_val("acc1_sdo", 32'(sdo[0]), 32'd1);
    for (int k = 0; k < 600 && vc < 0; k++) begin
      @(negedge clk);
      if (fr < 0 && sclk[0]) fr = cyc - c0;
      if (of < 0) begin
        if (!oe[0]) of = cyc - c0;
      end else if (oe[0]) begin
        bad_oe = 1'b1;
      end
      if (valid[0]) begin
        vc = cyc - c0;
        got = data[0];
      end
    end
    check_val("first_rise", 32'(fr), 32'd5);
    check_val("oe_fall", 32'(of), 32'd129);
    check_val("valid_lat", 32'(vc), 32'(exp_lat));
    check_val("rd_data", got, exp_data);
    for (int k = 0; k < 50 && bc < 0; k++) begin
      @(negedge clk);
      if (oe[0]) bad_oe = 1'b1;
      if (!busy[0]) bc = cyc - c0;
    end
    check_val("oe_low", 32'(bad_oe), 32'd0);
    check_val("busy_fall", 32'(bc), 32'(exp_lat + 8));
    check_val("data_hold", data[0], exp_data);
    check_val("instr", 32'(last_instr[0]), 32'(exp_instr));
    check_val("rises", 32'(last_rises[0]), 32'(exp_rises));
  endtask

  initial begin
    int c0, v0, f0, vc, bc;
    logic [31:0] got;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; addr[i] = 13'd0; len[i] = 2'd0;
    end

    // Reset state
    #12;
    check_val("rst_csb", 32'(csb[0]), 32'd1);
    check_val("rst_sclk", 32'(sclk[0]), 32'd0);
    check_val("rst_oe", 32'(oe[0]), 32'd0);
    check_val("rst_sdo", 32'(sdo[0]), 32'd0);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    check_val("rst_valid", 32'(valid[0]), 32'd0);
    check_val("rst_data", data[0], 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Chip ID read and four-byte read
    run_frame_a(13'h001, 2'd0, 32'h0000_0009, 32'h0000_0009, 16'h8001, 193, 24);
    run_frame_a(13'h0FF, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'hE0FF, 385, 48);

    // Requests at cycles 0, 10 and 100 -> one frame
    v0 = vcount[0]; f0 = frames[0];
    resp[0] = 32'h0000_ABCD;
    @(posedge clk); #1;
    addr[0] = 13'h002; len[0] = 2'd1; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (89) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check_val("busy_frames", 32'(frames[0] - f0), 32'd1);
    check_val("busy_valids", 32'(vcount[0] - v0), 32'd1);
    check_val("busy_data", data[0], 32'h0000_ABCD);
    check_val("busy_instr", 32'(last_instr[0]), 32'h0000_A002);

    // Reset during instruction bit 7 (SCLK high phase of rise 9, cycle 69)
    resp[0] = 32'h0000_0077;
    @(posedge clk); #1;
    addr[0] = 13'h010; len[0] = 2'd0; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (68) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_sclk", 32'(sclk[0]), 32'd1);
    check_val("pre_rst_oe", 32'(oe[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_csb", 32'(csb[0]), 32'd1);
    check_val("mid_rst_sclk", 32'(sclk[0]), 32'd0);
    check_val("mid_rst_oe", 32'(oe[0]), 32'd0);
    check_val("mid_rst_busy", 32'(busy[0]), 32'd0);
    check_val("mid_rst_data", data[0], 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame_a(13'h001, 2'd0, 32'h0000_0009, 32'h0000_0009, 16'h8001, 193, 24);

    // Back-to-back on instance B (CLK_DIV=2), rd_start held high
    resp[1] = 32'h0000_005A;
    @(posedge clk); #1;
    addr[1] = 13'h123; len[1] = 2'd0; start[1] = 1'b1; c0 = cyc;
    vc = -1; got = 32'd0;
    for (int k = 0; k < 300 && vc < 0; k++) begin
      @(negedge clk);
      if (valid[1]) begin vc = cyc - c0; got = data[1]; end
    end
    check_val("b2b_lat1", 32'(vc), 32'd97);
    check_val("b2b_data1", got, 32'h0000_005A);
    resp[1] = 32'h0000_00C3;
    bc = -1;
    for (int k = 0; k < 50 && bc < 0; k++) begin
      @(negedge clk);
      if (!busy[1]) bc = cyc - c0;
    end
    check_val("b2b_busy_fall", 32'(bc), 32'd101);
    @(negedge clk);
    check_val("b2b_reaccept_busy", 32'(busy[1]), 32'd1);
    check_val("b2b_reaccept_csb", 32'(csb[1]), 32'd0);
    @(posedge clk); #1 start[1] = 1'b0;
    vc = -1; got = 32'd0;
    for (int k = 0; k < 300 && vc < 0; k++) begin
      @(negedge clk);
      if (valid[1]) begin vc = cyc - c0; got = data[1]; end
    end
    check_val("b2b_lat2", 32'(vc), 32'd198);
    check_val("b2b_data2", got, 32'h0000_00C3);
    repeat (3) @(negedge clk);
    check_val("b2b_gap", 32'(last_gap[1]), 32'd5);
    check_val("b2b_instr", 32'(last_instr[1]), 32'h0000_8123);
    check_val("b2b_rises", 32'(last_rises[1]), 32'd24);

    // Bus contention never observed on either instance
    check_val("contention", 32'(contention[0] + contention[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
